// File: rtl/pad_ctrl_pkg.sv
// pad_ctrl_pkg: shared definitions for the pad control bank.
//   - byte offsets of the register map
//   - register index enum (word index = offset[5:2])
//   - bus FSM state enum
//   - default debounce counter width
package pad_ctrl_pkg;

  localparam int DEB_W_DEF = 8;

  localparam logic [5:0] OFF_OUT     = 6'h00;
  localparam logic [5:0] OFF_OE      = 6'h04;
  localparam logic [5:0] OFF_IN      = 6'h08;
  localparam logic [5:0] OFF_ALTSEL  = 6'h0C;
  localparam logic [5:0] OFF_PU      = 6'h10;
  localparam logic [5:0] OFF_PD      = 6'h14;
  localparam logic [5:0] OFF_CS      = 6'h18;
  localparam logic [5:0] OFF_DEBCNT  = 6'h1C;
  localparam logic [5:0] OFF_IRQEN   = 6'h20;
  localparam logic [5:0] OFF_IRQRISE = 6'h24;
  localparam logic [5:0] OFF_IRQFALL = 6'h28;
  localparam logic [5:0] OFF_PEND    = 6'h2C;

  typedef enum logic [3:0] {
    REG_OUT     = OFF_OUT[5:2],
    REG_OE      = OFF_OE[5:2],
    REG_IN      = OFF_IN[5:2],
    REG_ALTSEL  = OFF_ALTSEL[5:2],
    REG_PU      = OFF_PU[5:2],
    REG_PD      = OFF_PD[5:2],
    REG_CS      = OFF_CS[5:2],
    REG_DEBCNT  = OFF_DEBCNT[5:2],
    REG_IRQEN   = OFF_IRQEN[5:2],
    REG_IRQRISE = OFF_IRQRISE[5:2],
    REG_IRQFALL = OFF_IRQFALL[5:2],
    REG_PEND    = OFF_PEND[5:2]
  } reg_idx_e;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_e;

endpackage

// File: rtl/pad_ctrl_bank_if.sv
// pad_ctrl_bank_if: register bus between the SoC and the pad control bank.
//   valid : request, held by the master until ready
//   ready : one-cycle response strobe
//   addr  : byte address (word aligned)
//   we    : 1 write, 0 read
//   wdata : write data
//   rdata : read data, valid while ready is high
interface pad_ctrl_bank_if;
  logic        valid;
  logic        ready;
  logic [5:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, addr, we, wdata, input ready, rdata);
  modport slave  (input valid, addr, we, wdata, output ready, rdata);
endinterface

// File: rtl/pad_debounce.sv
// pad_debounce: input conditioning for one pad.
//   clk_i, rst_i : clock, synchronous active-high reset
//   p2c          : raw asynchronous pad input
//   thresh       : debounce threshold (cycles of disagreement before accept)
//   sync         : 2-flop synchronised input
//   stable       : debounced input
//   rise, fall   : one-cycle edge pulses on the debounced value
module pad_debounce #(
  parameter int DEB_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             p2c,
  input  logic [DEB_W-1:0] thresh,
  output logic             sync,
  output logic             stable,
  output logic             rise,
  output logic             fall
);

  logic             sync_p0, sync_p1;
  logic             stable_p2, stable_p3;
  logic [DEB_W-1:0] cnt;

  function automatic logic [DEB_W-1:0] sat_inc(input logic [DEB_W-1:0] v);
    return (v == '1) ? v : v + DEB_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      stable_p2 <= 1'b0;
      stable_p3 <= 1'b0;
      cnt       <= '0;
    end else begin
      // p0/p1: metastability synchroniser
      sync_p0 <= p2c;
      sync_p1 <= sync_p0;
      // p2: debounced value; '>=' lets a lowered threshold complete at once
      if (sync_p1 != stable_p2) begin
        if (cnt >= thresh) begin
          stable_p2 <= sync_p1;
          cnt       <= '0;
        end else begin
          cnt <= sat_inc(cnt);
        end
      end else begin
        cnt <= '0;
      end
      // p3: previous debounced value for edge detection
      stable_p3 <= stable_p2;
    end
  end

  assign sync   = sync_p1;
  assign stable = stable_p2;
  assign rise   = stable_p2 & ~stable_p3;
  assign fall   = ~stable_p2 & stable_p3;

endmodule

// File: rtl/pad_ctrl_bank.sv
// pad_ctrl_bank: core-side controller for a bank of tri-state pads.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   bus             : register bus (slave side)
//   alt_out_i/oe_i  : peripheral alternate-function output value / enable
//   alt_in_o        : synchronised pad input to peripherals
//   pad_c2p_o ...   : pad controls (c2p, c2p_en, cs, pu, pd)
//   pad_p2c_i       : asynchronous pad input
//   irq_o           : level interrupt, |(PEND & IRQEN)
module pad_ctrl_bank
  import pad_ctrl_pkg::*;
#(
  parameter int NUM_PADS = 8,
  parameter int DEB_W    = DEB_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pad_ctrl_bank_if.slave      bus,
  input  logic [NUM_PADS-1:0] alt_out_i,
  input  logic [NUM_PADS-1:0] alt_oe_i,
  output logic [NUM_PADS-1:0] alt_in_o,
  output logic [NUM_PADS-1:0] pad_c2p_o,
  output logic [NUM_PADS-1:0] pad_c2p_en_o,
  output logic [NUM_PADS-1:0] pad_cs_o,
  output logic [NUM_PADS-1:0] pad_pu_o,
  output logic [NUM_PADS-1:0] pad_pd_o,
  input  logic [NUM_PADS-1:0] pad_p2c_i,
  output logic                irq_o
);

  typedef logic [NUM_PADS-1:0] pad_vec_t;

  pad_vec_t         out_r, oe_r, altsel_r, pu_r, pd_r, cs_r;
  pad_vec_t         irqen_r, irqrise_r, irqfall_r, pend_r;
  logic [DEB_W-1:0] debcnt_r;
  pad_vec_t         sync_v, in_v, rise_v, fall_v;
  pad_vec_t         wpad, pend_set, pend_clr;
  bus_state_e       state, state_nxt;
  reg_idx_e         idx;
  logic             req, wr;
  logic [31:0]      rd_mux, rdata_r;
  logic             unused_bits;

  assign idx  = reg_idx_e'(bus.addr[5:2]);
  assign req  = (state == BUS_IDLE) && bus.valid;
  assign wr   = req && bus.we;
  assign wpad = bus.wdata[NUM_PADS-1:0];
  assign unused_bits = ^{bus.addr[1:0], bus.wdata};

  // Bus FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= BUS_IDLE;
    else       state <= state_nxt;
  end

  // Bus FSM: next state (RESP always lasts exactly one cycle)
  always_comb begin
    state_nxt = state;
    case (state)
      BUS_IDLE: if (bus.valid) state_nxt = BUS_RESP;
      BUS_RESP: state_nxt = BUS_IDLE;
      default:  state_nxt = BUS_IDLE;
    endcase
  end

  // Bus FSM: outputs
  always_comb begin
    bus.ready = (state == BUS_RESP);
  end

  assign bus.rdata = rdata_r;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_r     <= '0;
      oe_r      <= '0;
      altsel_r  <= '0;
      pu_r      <= '0;
      pd_r      <= '0;
      cs_r      <= '1;
      debcnt_r  <= '0;
      irqen_r   <= '0;
      irqrise_r <= '0;
      irqfall_r <= '0;
    end else if (wr) begin
      case (idx)
        REG_OUT:     out_r     <= wpad;
        REG_OE:      oe_r      <= wpad;
        REG_ALTSEL:  altsel_r  <= wpad;
        REG_PU:      pu_r      <= wpad;
        REG_PD:      pd_r      <= wpad;
        REG_CS:      cs_r      <= wpad;
        REG_DEBCNT:  debcnt_r  <= bus.wdata[DEB_W-1:0];
        REG_IRQEN:   irqen_r   <= wpad;
        REG_IRQRISE: irqrise_r <= wpad;
        REG_IRQFALL: irqfall_r <= wpad;
        default:     ;
      endcase
    end
  end

  // A new event in the same cycle as a W1C of that bit keeps the bit set.
  assign pend_clr = (wr && idx == REG_PEND) ? wpad : '0;
  assign pend_set = ((rise_v & irqrise_r) | (fall_v & irqfall_r)) & irqen_r;

  always_ff @(posedge clk_i) begin
    if (rst_i) pend_r <= '0;
    else       pend_r <= (pend_r & ~pend_clr) | pend_set;
  end

  always_comb begin
    rd_mux = '0;
    case (idx)
      REG_OUT:     rd_mux[NUM_PADS-1:0] = out_r;
      REG_OE:      rd_mux[NUM_PADS-1:0] = oe_r;
      REG_IN:      rd_mux[NUM_PADS-1:0] = in_v;
      REG_ALTSEL:  rd_mux[NUM_PADS-1:0] = altsel_r;
      REG_PU:      rd_mux[NUM_PADS-1:0] = pu_r;
      REG_PD:      rd_mux[NUM_PADS-1:0] = pd_r;
      REG_CS:      rd_mux[NUM_PADS-1:0] = cs_r;
      REG_DEBCNT:  rd_mux[DEB_W-1:0]    = debcnt_r;
      REG_IRQEN:   rd_mux[NUM_PADS-1:0] = irqen_r;
      REG_IRQRISE: rd_mux[NUM_PADS-1:0] = irqrise_r;
      REG_IRQFALL: rd_mux[NUM_PADS-1:0] = irqfall_r;
      REG_PEND:    rd_mux[NUM_PADS-1:0] = pend_r;
      default:     rd_mux = '0;
    endcase
  end

  // Read data is only non-zero during the response cycle of a read.
  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_r <= '0;
    else       rdata_r <= (req && !bus.we) ? rd_mux : '0;
  end

  assign pad_c2p_o    = (altsel_r & alt_out_i) | (~altsel_r & out_r);
  assign pad_c2p_en_o = (altsel_r & alt_oe_i)  | (~altsel_r & oe_r);
  assign pad_cs_o     = cs_r;
  assign pad_pu_o     = pu_r;
  assign pad_pd_o     = pd_r & ~pu_r;
  assign alt_in_o     = sync_v;
  assign irq_o        = |(pend_r & irqen_r);

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    pad_debounce #(.DEB_W(DEB_W)) u_deb (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .p2c    (pad_p2c_i[g]),
      .thresh (debcnt_r),
      .sync   (sync_v[g]),
      .stable (in_v[g]),
      .rise   (rise_v[g]),
      .fall   (fall_v[g])
    );
  end

endmodule

// File: tb/tb_pad_ctrl_bank.sv
// tb_pad_ctrl_bank: directed bench for pad_ctrl_bank (NUM_PADS=8, DEB_W=8).
module tb_pad_ctrl_bank;
  import pad_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] alt_out = '0, alt_oe = '0, p2c = '0;
  logic [7:0] alt_in, c2p, c2p_en, cs, pu, pd;
  logic       irq;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [31:0] rd;

  pad_ctrl_bank_if bus_if();

  pad_ctrl_bank #(.NUM_PADS(8), .DEB_W(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus_if),
    .alt_out_i    (alt_out),
    .alt_oe_i     (alt_oe),
    .alt_in_o     (alt_in),
    .pad_c2p_o    (c2p),
    .pad_c2p_en_o (c2p_en),
    .pad_cs_o     (cs),
    .pad_pu_o     (pu),
    .pad_pd_o     (pd),
    .pad_p2c_i    (p2c),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_xfer(input logic w, input logic [5:0] a, input logic [31:0] d,
                          output logic [31:0] q);
    int n;
    bus_if.valid = 1'b1;
    bus_if.we    = w;
    bus_if.addr  = a;
    bus_if.wdata = d;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus_if.ready && n < 8);
    if (!bus_if.ready) chk_val("bus_timeout", 32'd0, 32'd1);
    q = bus_if.rdata;
    bus_if.valid = 1'b0;
    bus_if.we    = 1'b0;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus_xfer(1'b1, a, d, q);
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] q);
    bus_xfer(1'b0, a, 32'd0, q);
  endtask

  initial begin
    int nrdy;
    bus_if.valid = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;

    // Reset state
    tick(3);
    chk_val("rst_c2p_en", 32'(c2p_en), 32'h00);
    chk_val("rst_c2p", 32'(c2p), 32'h00);
    chk_val("rst_cs", 32'(cs), 32'hFF);
    chk_val("rst_pu_pd", {pu, pd}, 32'h0000);
    chk_val("rst_irq", 32'(irq), 32'd0);
    chk_val("rst_ready", 32'(bus_if.ready), 32'd0);
    chk_val("rst_rdata", bus_if.rdata, 32'd0);
    rst = 1'b0;
    tick(1);
    bus_read(OFF_CS, rd);
    chk_val("rd_cs", rd, 32'h000000FF);

    // Register GPIO and alternate-function mux
    bus_write(OFF_OUT, 32'hFFFF_FFA5);
    bus_write(OFF_OE, 32'h0000_000F);
    chk_val("c2p_gpio", 32'(c2p), 32'hA5);
    chk_val("en_gpio", 32'(c2p_en), 32'h0F);
    bus_read(OFF_OUT, rd);
    chk_val("rd_out_upper0", rd, 32'h0000_00A5);
    bus_write(OFF_ALTSEL, 32'h01);
    chk_val("en_alt", 32'(c2p_en), 32'h0E);
    chk_val("c2p_alt", 32'(c2p), 32'hA4);
    alt_out = 8'h01;
    alt_oe  = 8'h01;
    #1;
    chk_val("en_alt_on", 32'(c2p_en), 32'h0F);
    chk_val("c2p_alt_on", 32'(c2p), 32'hA5);
    alt_out = 8'h00;
    alt_oe  = 8'h00;

    // Pull-up wins over pull-down
    bus_write(OFF_PU, 32'h03);
    bus_write(OFF_PD, 32'h03);
    chk_val("pu_both", 32'(pu), 32'h03);
    chk_val("pd_both", 32'(pd), 32'h00);
    bus_read(OFF_PD, rd);
    chk_val("rd_pd", rd, 32'h03);
    bus_write(OFF_PD, 32'h0F);
    chk_val("pd_partial", 32'(pd), 32'h0C);

    // Unmapped address
    bus_write(6'h30, 32'hFFFF_FFFF);
    bus_read(6'h30, rd);
    chk_val("rd_unmapped", rd, 32'd0);
    bus_read(OFF_OUT, rd);
    chk_val("rd_out_kept", rd, 32'h0000_00A5);

    // Back-to-back requests: ready every other cycle
    tick(1);
    bus_if.valid = 1'b1;
    bus_if.we    = 1'b0;
    bus_if.addr  = OFF_CS;
    nrdy = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (bus_if.ready) nrdy++;
    end
    bus_if.valid = 1'b0;
    chk_val("b2b_ready_cnt", 32'(nrdy), 32'd2);
    tick(1);

    // Glitch of 3 cycles with DEBCNT=4 never reaches IN
    bus_write(OFF_DEBCNT, 32'd4);
    p2c[0] = 1'b1;
    tick(3);
    p2c[0] = 1'b0;
    tick(8);
    bus_read(OFF_IN, rd);
    chk_val("glitch_in", rd, 32'd0);

    // Held input: alt_in after 2 cycles, IN after 2+5, PEND one cycle later
    bus_write(OFF_IRQEN, 32'h01);
    bus_write(OFF_IRQRISE, 32'h01);
    p2c[0] = 1'b1;
    tick(2);
    chk_val("alt_in_lat2", 32'(alt_in), 32'h01);
    tick(5);
    chk_val("irq_before_pend", 32'(irq), 32'd0);
    tick(1);
    chk_val("irq_rise", 32'(irq), 32'd1);
    bus_read(OFF_IN, rd);
    chk_val("in_held", rd, 32'h01);
    bus_read(OFF_PEND, rd);
    chk_val("pend_rise", rd, 32'h01);
    bus_write(OFF_PEND, 32'h01);
    chk_val("irq_w1c", 32'(irq), 32'd0);
    bus_read(OFF_PEND, rd);
    chk_val("pend_w1c", rd, 32'h00);

    // W1C in the same cycle as a new rising edge: set wins (DEBCNT=0, latency 3)
    bus_write(OFF_DEBCNT, 32'd0);
    p2c[0] = 1'b0;
    tick(10);
    bus_read(OFF_PEND, rd);
    chk_val("pend_after_fall", rd, 32'h00);
    p2c[0] = 1'b1;
    tick(3);
    bus_write(OFF_PEND, 32'h01);
    chk_val("irq_set_wins", 32'(irq), 32'd1);
    bus_read(OFF_PEND, rd);
    chk_val("pend_set_wins", rd, 32'h01);

    // Reset mid-count with PEND set
    bus_write(OFF_DEBCNT, 32'd4);
    p2c[1] = 1'b1;
    tick(4);
    chk_val("irq_pre_rst", 32'(irq), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_val("irq_post_rst", 32'(irq), 32'd0);
    chk_val("cs_post_rst", 32'(cs), 32'hFF);
    chk_val("en_post_rst", 32'(c2p_en), 32'h00);
    chk_val("alt_in_post_rst", 32'(alt_in), 32'h00);
    bus_read(OFF_PEND, rd);
    chk_val("pend_post_rst", rd, 32'h00);
    bus_read(OFF_DEBCNT, rd);
    chk_val("debcnt_post_rst", rd, 32'h00);
    tick(10);
    bus_read(OFF_PEND, rd);
    chk_val("pend_after_release", rd, 32'h00);
    chk_val("irq_after_release", 32'(irq), 32'd0);
    bus_read(OFF_IN, rd);
    chk_val("in_after_release", rd, 32'h03);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
